mem_port_arbiter: RTL

//  Shares the single-ported simulation memory between instruction fetch (F) and load/store (D) requesters.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (F) and load/store (D) requests onto one single-ported memory port.
// One transaction in flight; D wins ties except when F has been passed over MAX_STREAK times.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req_valid_i,
    output logic                  f_req_ready_o,
    input  logic [DATA_WIDTH-1:0] f_pc_i,
    output logic                  f_rsp_valid_o,
    input  logic                  f_rsp_ready_i,
    output logic [INST_WIDTH-1:0] f_rsp_inst_o,
    output logic                  f_rsp_err_o,
    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic                  d_req_wr_i,
    input  logic [DATA_WIDTH-1:0] d_req_addr_i,
    input  logic [DATA_WIDTH-1:0] d_req_wdata_i,
    input  logic [2:0]            d_req_wid_i,
    output logic                  d_rsp_valid_o,
    input  logic                  d_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] d_rsp_rdata_o,
    output logic                  d_rsp_err_o,
    output logic [DATA_WIDTH-1:0] mem_pc_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_enwr_o,
    output logic                  mem_en_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [2:0]            mem_wid_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic [INST_WIDTH-1:0] mem_inst_i,
    input  logic                  mem_unalign_i,
    input  logic                  mem_illegal_i
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    // IDLE: grant decision | D_WAIT: load data arriving | D_RESP/F_RESP: holding response
    typedef enum logic [1:0] {IDLE, D_WAIT, D_RESP, F_RESP} state_t;

    state_t                state, state_nxt;
    logic [SW-1:0]         streak, streak_nxt;
    logic                  grant_d, grant_f, acc_d, acc_f;
    logic [DATA_WIDTH-1:0] last_pc, d_rdata_q;
    logic [INST_WIDTH-1:0] f_inst_q;
    logic                  d_err_q, f_err_q;
    logic [2:0]            ld_wid_q;

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [2:0] wid);
        logic [DATA_WIDTH-1:0] r;
        case (wid)
            3'b000:  r = {{(DATA_WIDTH-8){v[7]}}, v[7:0]};
            3'b001:  r = {{(DATA_WIDTH-16){v[15]}}, v[15:0]};
            3'b010:  r = {{(DATA_WIDTH-32){v[31]}}, v[31:0]};
            3'b011:  r = v;
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, v[7:0]};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, v[15:0]};
            3'b110:  r = {{(DATA_WIDTH-32){1'b0}}, v[31:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign grant_d = d_req_valid_i && !(f_req_valid_i && streak == STREAK_MAX);
    assign grant_f = f_req_valid_i && !grant_d;
    assign acc_d   = !rst && state == IDLE && grant_d;
    assign acc_f   = !rst && state == IDLE && grant_f;

    assign d_req_ready_o = acc_d;
    assign f_req_ready_o = acc_f;
    assign d_rsp_valid_o = state == D_RESP;
    assign f_rsp_valid_o = state == F_RESP;
    assign d_rsp_rdata_o = d_rdata_q;
    assign d_rsp_err_o   = d_err_q;
    assign f_rsp_inst_o  = f_inst_q;
    assign f_rsp_err_o   = f_err_q;

    always_comb begin
        mem_pc_o    = last_pc;
        mem_addr_o  = '0;
        mem_enwr_o  = 1'b1;
        mem_en_o    = 1'b0;
        mem_wdata_o = '0;
        mem_wid_o   = '0;
        if (acc_f) begin
            mem_pc_o = f_pc_i;
        end
        if (acc_d) begin
            mem_en_o   = 1'b1;
            mem_enwr_o = !d_req_wr_i;
            mem_addr_o = d_req_addr_i;
            mem_wid_o  = d_req_wid_i;
            if (d_req_wr_i) begin
                mem_wdata_o = d_req_wdata_i;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        case (state)
            IDLE: begin
                if (!f_req_valid_i || acc_f) begin
                    streak_nxt = '0;
                end else if (acc_d && streak != STREAK_MAX) begin
                    streak_nxt = streak + SW'(1);
                end
                if (acc_d) begin
                    state_nxt = d_req_wr_i ? D_RESP : D_WAIT;
                end else if (acc_f) begin
                    state_nxt = F_RESP;
                end
            end
            D_WAIT:  state_nxt = D_RESP;
            D_RESP:  if (d_rsp_ready_i) state_nxt = IDLE;
            F_RESP:  if (f_rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            last_pc   <= '0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
            f_inst_q  <= '0;
            f_err_q   <= 1'b0;
            ld_wid_q  <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            if (acc_f) begin
                last_pc  <= f_pc_i;
                f_err_q  <= mem_illegal_i;
                f_inst_q <= mem_illegal_i ? '0 : mem_inst_i;
            end
            if (acc_d) begin
                ld_wid_q  <= d_req_wid_i;
                d_err_q   <= mem_unalign_i || (d_req_wid_i == 3'b111);
                d_rdata_q <= '0;
            end
            // the flag is also sampled with the data in case the memory registers it
            if (state == D_WAIT) begin
                d_err_q   <= d_err_q || mem_unalign_i;
                d_rdata_q <= (d_err_q || mem_unalign_i) ? '0 : extend(mem_rdata_i, ld_wid_q);
            end
        end
    end
endmodule
